// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver/transmitter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 50 MHz clock, 8.7 us bit period
    localparam int c_clks_per_bit_dflt = 435;
    localparam int c_data_w            = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Byte-delivery handshake and status pulses of the UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic [c_data_w-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                frame_err;
    logic                overrun;

    // Receiver side
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer with asynchronous reset to RESET_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with single-byte holding register,
//               valid/ready handoff, framing-error and overrun pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_clks_per_bit_dflt
) (
    input  wire logic clk,
    input  wire logic Rst,
    input  wire logic host_tx,
    uart_rx_if.master bus
);

    localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_half  = (CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_half - 1);
    localparam logic [2:0]         c_last_bit = 3'(c_data_w - 1);

    uart_state_t           r_state;
    uart_state_t           w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [2:0]            r_bit_idx;
    logic [c_data_w-1:0]   r_shift;
    logic [c_data_w-1:0]   r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic                  w_line;
    logic                  w_cnt_run;
    logic                  w_shift_en;
    logic                  w_byte_done;
    logic                  w_frame_err;
    logic                  w_consume;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (Rst),
        .i_d (host_tx),
        .o_q (w_line)
    );

    // State register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode and per-cycle sampling strobes
    always_comb begin
        w_state_next = r_state;
        w_cnt_run    = 1'b0;
        w_shift_en   = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_line) w_state_next = START;
            end
            START: begin
                w_cnt_run = 1'b1;
                if (r_cnt == c_cnt_half) w_state_next = w_line ? IDLE : DATA;
            end
            DATA: begin
                w_cnt_run = 1'b1;
                if (r_cnt == c_cnt_full) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == c_last_bit) w_state_next = STOP;
                end
            end
            STOP: begin
                w_cnt_run = 1'b1;
                if (r_cnt == c_cnt_full) begin
                    if (w_line) begin
                        w_byte_done  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_line) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Baud counter restarts on every state change and at each data-bit sample
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst)                                     r_cnt <= '0;
        else if ((w_state_next != r_state) || w_shift_en) r_cnt <= '0;
        else if (w_cnt_run)                          r_cnt <= r_cnt + 1'b1;
    end

    // Bit index and LSB-first shift register
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == IDLE) && (w_state_next == START)) r_bit_idx <= '0;
            else if (w_shift_en)                              r_bit_idx <= r_bit_idx + 1'b1;
            if (w_shift_en) r_shift <= {w_line, r_shift[c_data_w-1:1]};
        end
    end

    assign w_consume = r_rx_valid & bus.rx_ready;

    // Holding register: a completing byte loads if the slot is empty or being
    // consumed this cycle, otherwise it is dropped and flagged as overrun
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                if (!r_rx_valid || w_consume) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun  <= 1'b1;
                end
            end else if (w_consume) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx with byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT = 16;

    logic clk     = 1'b0;
    logic Rst     = 1'b1;
    logic host_tx = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (BIT)
    ) dut (
        .clk     (clk),
        .Rst     (Rst),
        .host_tx (host_tx),
        .bus     (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];

    // Observe after inputs settle, before the next rising edge
    always @(negedge clk) begin
        #2;
        if (bus.rx_valid && bus.rx_ready) rx_q.push_back(bus.rx_data);
        if (bus.frame_err) fe_cnt++;
        if (bus.overrun)   ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        host_tx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            host_tx = b[i];
            repeat (BIT) @(negedge clk);
        end
        host_tx = stop_bit;
        repeat (BIT) @(negedge clk);
        host_tx = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 40 * BIT) begin
            @(negedge clk);
            guard++;
            while (rx_q.size() > 0 && exp_q.size() > 0) begin
                g = rx_q.pop_front();
                e = exp_q.pop_front();
                check(tag, 32'(g), 32'(e));
            end
        end
        check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2 * BIT) @(negedge clk);
        check({tag, "_extra"}, 32'(rx_q.size()), 32'd0);
        rx_q.delete();
    endtask

    initial begin
        int fe0;
        int ov0;
        logic [7:0] b;

        bus.rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_data",  32'(bus.rx_data),  32'd0);
        check("rst_ferr",  32'(bus.frame_err), 32'd0);
        check("rst_ovr",   32'(bus.overrun),  32'd0);
        check("rst_state", 32'(dut.r_state),  32'(IDLE));
        Rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // Single byte
        fe0 = fe_cnt; ov0 = ov_cnt;
        exp_q.push_back(8'hEB);
        send_byte(8'hEB, 1'b1);
        drain("byte_eb");
        check("eb_ferr", 32'(fe_cnt - fe0), 32'd0);
        check("eb_ovr",  32'(ov_cnt - ov0), 32'd0);

        // Back-to-back frames, no idle gap
        ov0 = ov_cnt;
        for (int v = 235; v <= 254; v++) begin
            exp_q.push_back(8'(v));
            send_byte(8'(v), 1'b1);
        end
        drain("b2b");
        check("b2b_ovr", 32'(ov_cnt - ov0), 32'd0);

        // Short low glitch is rejected at the start-bit midpoint
        fe0 = fe_cnt;
        host_tx = 1'b0;
        repeat (4) @(negedge clk);
        host_tx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_rx",    32'(rx_q.size()),   32'd0);
        check("glitch_ferr",  32'(fe_cnt - fe0),  32'd0);
        check("glitch_valid", 32'(bus.rx_valid),  32'd0);
        check("glitch_state", 32'(dut.r_state),   32'(IDLE));

        // Framing error followed by a break, then a good byte
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        host_tx = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        host_tx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_rx",     32'(rx_q.size()),  32'd0);
        check("ferr_valid",  32'(bus.rx_valid), 32'd0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        drain("after_ferr");

        // Overrun: second byte dropped while first is held
        bus.rx_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (BIT) @(negedge clk);
        check("ovr_data",   32'(bus.rx_data),   32'h11);
        check("ovr_valid",  32'(bus.rx_valid),  32'd1);
        check("ovr_pulses", 32'(ov_cnt - ov0),  32'd1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        check("ovr_clear",  32'(bus.rx_valid),  32'd0);
        drain("ovr_byte");
        bus.rx_ready = 1'b1;

        // Asynchronous reset in the middle of a frame
        bus.rx_ready = 1'b0;
        send_byte(8'h77, 1'b1);
        b = 8'hC3;
        host_tx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            host_tx = b[i];
            repeat (BIT) @(negedge clk);
        end
        host_tx = b[3];
        repeat (BIT / 2) @(negedge clk);
        #3 Rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.rx_valid), 32'd0);
        check("arst_data",  32'(bus.rx_data),  32'd0);
        check("arst_state", 32'(dut.r_state),  32'(IDLE));
        host_tx = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b1;
        repeat (4) @(negedge clk);
        Rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check("arst_norx", 32'(rx_q.size()), 32'd0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 435, clock cycles per bit: 50 MHz clk at an 8.7 us bit period.
REQ-002 Port clk  input  1  system clock, 50 MHz, rising edge.
REQ-003 Port Rst  input  1  reset; one clock domain; asynchronous, active-high.
REQ-004 Port host_tx  input  1  serial line from host; asynchronous to clk; idles high.
REQ-005 Port rx_data  output  8  received byte, LSB first on the line.
REQ-006 Port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 Port rx_ready  input  1  downstream (perceptron core) accepts the byte.
REQ-008 Port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 Port overrun  output  1  one-cycle pulse: a byte completed while the holding register was full.

Function
REQ-010 host_tx SHALL pass through a 2-flop synchronizer before any use; "line" below means the synchronized value.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 IDLE: line low -> START with bit counter cleared; otherwise stay.
REQ-013 START: after CLKS_PER_BIT/2 cycles (217), sample line; low -> DATA; high -> IDLE as a glitch, with no outputs.
REQ-014 DATA: sample every CLKS_PER_BIT cycles into bit index 0..7, LSB first; after bit 7 -> STOP.
REQ-015 STOP: sample once after CLKS_PER_BIT cycles.
REQ-016 Stop bit high: load the byte into the holding register and -> IDLE.
REQ-017 Stop bit low: pulse frame_err for 1 cycle, discard the byte and -> WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until line is high, then -> IDLE, so no false start is taken from a break.
REQ-019 rx_valid SHALL rise on the cycle after the stop-bit sample cycle; rx_data SHALL be stable while rx_valid is high.
REQ-020 Handshake: the byte is consumed on a cycle where rx_valid and rx_ready are both high; rx_valid clears on the next edge unless a new byte loads on that edge.
REQ-021 A new byte completing on the same cycle as consumption SHALL load, keep rx_valid high and not pulse overrun.
REQ-022 A new byte completing while rx_valid is high without consumption SHALL be dropped: old byte kept, overrun pulsed for 1 cycle.
REQ-023 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 on every state change.
REQ-024 rx_ready SHALL be ignored while rx_valid is low.
REQ-025 Receive SHALL be continuous: back-to-back frames with a 1-bit stop and no idle gap are received without loss.

Reset
REQ-026 Rst SHALL force all of the following immediately, regardless of clk: FSM -> IDLE; counters -> 0; shift and holding registers -> 0x00; rx_valid, frame_err, overrun -> 0; synchronizer flops -> 1.
REQ-027 Rst asserted mid-frame SHALL abort the frame with no output.
REQ-028 After Rst deasserts, a frame SHALL be recognized only from a subsequent high-to-low transition of the synchronized line.

Structure
REQ-029 Package uart_pkg SHALL hold the default CLKS_PER_BIT, the data width (8) and the FSM state typedef, for reuse by the UART transmitter.
REQ-030 The 2-flop synchronizer SHALL be sub-module sync2 (async active-high reset, reset value parameterized, here 1).
REQ-031 Target size SHALL be 120-400 lines of RTL, with no RAM or FIFO; the holding register is a single byte.

Verification
REQ-032 Send 0xEB (start, 8 bits LSB first, stop) at 8700 ns/bit, rx_ready=1 -> one rx_valid pulse with rx_data=0xEB; frame_err=0, overrun=0.
REQ-033 Send bytes 235..254 back-to-back with no idle gap, rx_ready=1 -> 20 rx_valid events with values 235..254 in order.
REQ-034 Drive host_tx low for 100 cycles, then high -> no rx_valid, no frame_err, FSM back to IDLE.
REQ-035 Send 0x55 with the stop bit low, then line high -> frame_err pulses once, rx_valid stays 0; a following 0xA5 is received correctly.
REQ-036 Hold rx_ready=0 and send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; rx_ready=1 for one cycle -> rx_valid clears.
REQ-037 Assert Rst during bit 3 of 0xC3, release, then send 0x3C -> only 0x3C is delivered.
